// File: rtl/countdown_ctrl_pkg.sv
// Shared types and BCD helpers for the MM:SS countdown controller.
package countdown_pkg;

  localparam int SEC_MAX_TENS = 5;
  localparam int MIN_MAX      = 99;
  localparam int BCD_WIDTH    = 4;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  typedef struct packed {
    logic [BCD_WIDTH-1:0] m10;
    logic [BCD_WIDTH-1:0] m1;
    logic [BCD_WIDTH-1:0] s10;
    logic [BCD_WIDTH-1:0] s1;
  } mmss_t;

  // Seconds wrap 59 -> 00 without touching the minutes.
  function automatic mmss_t inc_sec(input mmss_t v);
    mmss_t r;
    r = v;
    if (v.s1 == 4'd9) begin
      r.s1 = 4'd0;
      if (v.s10 == 4'(SEC_MAX_TENS)) begin
        r.s10 = 4'd0;
      end else begin
        r.s10 = v.s10 + 4'd1;
      end
    end else begin
      r.s1 = v.s1 + 4'd1;
    end
    return r;
  endfunction

  function automatic mmss_t inc_min(input mmss_t v);
    mmss_t r;
    r = v;
    if (v.m1 == 4'd9) begin
      r.m1 = 4'd0;
      if (v.m10 == 4'(MIN_MAX / 10)) begin
        r.m10 = 4'd0;
      end else begin
        r.m10 = v.m10 + 4'd1;
      end
    end else begin
      r.m1 = v.m1 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_ctrl_mmss_counter.sv
// Four-digit BCD MM:SS register with load and one-second decrement.
import countdown_pkg::*;

module mmss_counter (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  mmss_t load_val,
  input  logic  dec_en,
  output mmss_t next_value,
  output logic  is_zero
);

  mmss_t value_q;
  mmss_t value_d;
  mmss_t dec_s;

  // Borrow chain: seconds ones -> seconds tens -> minutes ones -> minutes tens.
  always_comb begin
    dec_s = value_q;
    if (value_q.s1 != 4'd0) begin
      dec_s.s1 = value_q.s1 - 4'd1;
    end else begin
      dec_s.s1 = 4'd9;
      if (value_q.s10 != 4'd0) begin
        dec_s.s10 = value_q.s10 - 4'd1;
      end else begin
        dec_s.s10 = 4'(SEC_MAX_TENS);
        if (value_q.m1 != 4'd0) begin
          dec_s.m1 = value_q.m1 - 4'd1;
        end else begin
          dec_s.m1 = 4'd9;
          if (value_q.m10 != 4'd0) begin
            dec_s.m10 = value_q.m10 - 4'd1;
          end else begin
            dec_s.m10 = 4'd9;
          end
        end
      end
    end
  end

  always_comb begin
    if (load) begin
      value_d = load_val;
    end else if (dec_en) begin
      value_d = dec_s;
    end else begin
      value_d = value_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign next_value = value_d;
  assign is_zero    = (dec_s == '0);

endmodule

// File: rtl/countdown_ctrl.sv
// MM:SS countdown sequencer feeding a 4-digit seven-segment display block.
import countdown_pkg::*;

module countdown_ctrl #(
  parameter int DONE_TICKS    = 10,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  output logic [3:0] digit_3,
  output logic [3:0] digit_2,
  output logic [3:0] digit_1,
  output logic [3:0] digit_0,
  output logic       enable_3,
  output logic       enable_2,
  output logic       enable_1,
  output logic       enable_0,
  output logic       running,
  output logic       expired
);

  state_e     state_q, state_d;
  mmss_t      preset_q, preset_d;
  logic       blink_q, blink_d;
  logic [7:0] done_cnt_q, done_cnt_d;
  mmss_t      disp_q, disp_d;
  logic [3:0] en_q, en_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;
  logic       load_s, dec_s, post_zero_s;
  mmss_t      count_next_s;

  mmss_counter u_count (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_val   (preset_q),
    .dec_en     (dec_s),
    .next_value (count_next_s),
    .is_zero    (post_zero_s)
  );

  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    blink_d    = blink_q;
    done_cnt_d = done_cnt_q;
    load_s     = 1'b0;
    dec_s      = 1'b0;
    if (btn_clear && (state_q != IDLE)) begin
      state_d    = IDLE;
      load_s     = 1'b1;
      blink_d    = 1'b1;
      done_cnt_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_start && (preset_q != '0)) begin
            state_d = RUN;
            load_s  = 1'b1;
          end else begin
            if (btn_inc_min && btn_inc_sec) begin
              preset_d = inc_sec(inc_min(preset_q));
            end else if (btn_inc_min) begin
              preset_d = inc_min(preset_q);
            end else if (btn_inc_sec) begin
              preset_d = inc_sec(preset_q);
            end else begin
              preset_d = preset_q;
            end
          end
        end
        RUN: begin
          // Reaching 00:00 wins over a simultaneous pause so 00:00 never sits in PAUSE/RUN.
          if (tick) begin
            dec_s = 1'b1;
            if (post_zero_s) begin
              state_d    = DONE;
              blink_d    = 1'b1;
              done_cnt_d = 8'd0;
            end else if (btn_start) begin
              state_d = PAUSE;
            end else begin
              state_d = RUN;
            end
          end else if (btn_start) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (btn_start) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        DONE: begin
          if (tick) begin
            if (done_cnt_q == 8'(DONE_TICKS - 1)) begin
              state_d    = IDLE;
              load_s     = 1'b1;
              blink_d    = 1'b1;
              done_cnt_d = 8'd0;
            end else begin
              blink_d    = ~blink_q;
              done_cnt_d = done_cnt_q + 8'd1;
            end
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from next-state values so they register on the same edge.
  always_comb begin
    case (state_d)
      IDLE:       disp_d = preset_d;
      RUN, PAUSE: disp_d = count_next_s;
      DONE:       disp_d = '0;
      default:    disp_d = '0;
    endcase
    if (state_d == DONE) begin
      en_d = {4{blink_d}};
    end else if (BLANK_LEADING && (disp_d.m10 == 4'd0)) begin
      en_d = 4'b0111;
    end else begin
      en_d = 4'b1111;
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      preset_q   <= '0;
      blink_q    <= 1'b1;
      done_cnt_q <= 8'd0;
      disp_q     <= '0;
      en_q       <= {~BLANK_LEADING, 3'b111};
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      blink_q    <= blink_d;
      done_cnt_q <= done_cnt_d;
      disp_q     <= disp_d;
      en_q       <= en_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
    end
  end

  assign digit_3  = disp_q.m10;
  assign digit_2  = disp_q.m1;
  assign digit_1  = disp_q.s10;
  assign digit_0  = disp_q.s1;
  assign enable_3 = en_q[3];
  assign enable_2 = en_q[2];
  assign enable_1 = en_q[1];
  assign enable_0 = en_q[0];
  assign running  = running_q;
  assign expired  = expired_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed steps plus random events against a seconds-level model.
module tb_countdown_ctrl;

  localparam int DT = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, tick = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
  logic btn_inc_min = 1'b0, btn_inc_sec = 1'b0;
  logic [3:0] digit_3, digit_2, digit_1, digit_0;
  logic enable_3, enable_2, enable_1, enable_0, running, expired;

  int errors = 0;
  int checks = 0;

  // Model state: preset as minutes/seconds, count as total seconds.
  int m_mode = M_IDLE, p_min = 0, p_sec = 0, c_secs = 0, m_blink = 1, m_dcnt = 0;

  always #5 clk = ~clk;

  countdown_ctrl #(.DONE_TICKS(DT), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
    .btn_inc_min(btn_inc_min), .btn_inc_sec(btn_inc_sec),
    .digit_3(digit_3), .digit_2(digit_2), .digit_1(digit_1), .digit_0(digit_0),
    .enable_3(enable_3), .enable_2(enable_2), .enable_1(enable_1), .enable_0(enable_0),
    .running(running), .expired(expired)
  );

  wire [15:0] disp = {digit_3, digit_2, digit_1, digit_0};
  wire [15:0] ens  = {12'h000, enable_3, enable_2, enable_1, enable_0};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, c, s, t, im, is);
    if (r) begin
      m_mode = M_IDLE; p_min = 0; p_sec = 0; c_secs = 0; m_blink = 1; m_dcnt = 0;
    end else if (c && m_mode != M_IDLE) begin
      m_mode = M_IDLE; c_secs = p_min * 60 + p_sec; m_blink = 1; m_dcnt = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (s && (p_min + p_sec) > 0) begin
            c_secs = p_min * 60 + p_sec;
            m_mode = M_RUN;
          end else begin
            if (im) p_min = (p_min + 1) % 100;
            if (is) p_sec = (p_sec + 1) % 60;
          end
        end
        M_RUN: begin
          if (t) begin
            c_secs = c_secs - 1;
            if (c_secs == 0) begin
              m_mode = M_DONE; m_blink = 1; m_dcnt = 0;
            end else if (s) m_mode = M_PAUSE;
          end else if (s) m_mode = M_PAUSE;
        end
        M_PAUSE: if (s) m_mode = M_RUN;
        default: begin
          if (t) begin
            m_dcnt++;
            if (m_dcnt == DT) begin
              m_mode = M_IDLE; c_secs = p_min * 60 + p_sec; m_blink = 1; m_dcnt = 0;
            end else m_blink = 1 - m_blink;
          end
        end
      endcase
    end
  endtask

  function automatic logic [15:0] exp_disp();
    int mm, ss;
    if (m_mode == M_IDLE) begin mm = p_min; ss = p_sec; end
    else if (m_mode == M_DONE) begin mm = 0; ss = 0; end
    else begin mm = c_secs / 60; ss = c_secs % 60; end
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] exp_en();
    logic [15:0] d;
    d = exp_disp();
    if (m_mode == M_DONE) return (m_blink != 0) ? 16'h000F : 16'h0000;
    else if (d[15:12] == 4'd0) return 16'h0007;
    else return 16'h000F;
  endfunction

  task automatic step(input logic r, c, s, t, im, is);
    rst = r; btn_clear = c; btn_start = s; tick = t; btn_inc_min = im; btn_inc_sec = is;
    @(posedge clk);
    model_edge(r, c, s, t, im, is);
    #1;
    chk("display", disp, exp_disp());
    chk("enables", ens, exp_en());
    chk("running", {15'd0, running}, {15'd0, m_mode == M_RUN});
    chk("expired", {15'd0, expired}, {15'd0, m_mode == M_DONE});
    rst = 1'b0; btn_clear = 1'b0; btn_start = 1'b0; tick = 1'b0;
    btn_inc_min = 1'b0; btn_inc_sec = 1'b0;
  endtask

  task automatic do_rst();   step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_start(); step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_tick();  step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_clear(); step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_imin();  step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic do_isec();  step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

  initial begin
    do_rst();
    do_rst();
    chk("reset_display", disp, 16'h0000);
    chk("reset_enables", ens, 16'h0007);

    for (int i = 0; i < 61; i++) do_isec();
    for (int i = 0; i < 3; i++) do_imin();
    chk("preset_0301", disp, 16'h0301);
    chk("preset_0301_en", ens, 16'h0007);

    do_rst();
    for (int i = 0; i < 3; i++) do_isec();
    do_start();
    chk("start_running", {15'd0, running}, 16'h0001);
    chk("start_disp", disp, 16'h0003);
    do_tick();
    chk("tick1", disp, 16'h0002);
    do_tick();
    chk("tick2", disp, 16'h0001);
    do_tick();
    chk("tick3", disp, 16'h0000);
    chk("done_expired", {15'd0, expired}, 16'h0001);
    chk("done_entry_en", ens, 16'h000F);
    do_tick();
    chk("done_t1_en", ens, 16'h0000);
    do_tick();
    chk("done_t2_en", ens, 16'h000F);
    do_tick();
    chk("done_t3_en", ens, 16'h0000);
    do_tick();
    chk("done_exit_disp", disp, 16'h0003);
    chk("done_exit_expired", {15'd0, expired}, 16'h0000);

    do_isec();
    do_isec();
    do_start();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tick_start_disp", disp, 16'h0004);
    chk("tick_start_paused", {15'd0, running}, 16'h0000);
    do_tick();
    do_tick();
    chk("pause_frozen", disp, 16'h0004);
    do_start();
    chk("resume_running", {15'd0, running}, 16'h0001);
    do_clear();

    do_rst();
    for (int i = 0; i < 10; i++) do_imin();
    do_start();
    do_tick();
    chk("borrow_0959", disp, 16'h0959);
    chk("borrow_en", ens, 16'h0007);

    do_rst();
    do_imin();
    do_imin();
    do_start();
    for (int i = 0; i < 30; i++) do_tick();
    chk("run_0130", disp, 16'h0130);
    do_clear();
    chk("clear_disp", disp, 16'h0200);
    chk("clear_idle", {15'd0, running}, 16'h0000);
    do_start();
    do_tick();
    do_rst();
    chk("midrun_rst_disp", disp, 16'h0000);
    do_start();
    chk("zero_start_ignored", {15'd0, running}, 16'h0000);

    // Random events; clear and start are kept exclusive of the increment buttons.
    for (int i = 0; i < 1500; i++) begin
      logic r, c, s, t, im, is;
      int sel;
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 19);
      c = (sel == 0);
      s = (sel == 1 || sel == 2);
      im = (sel == 3);
      is = (sel >= 4 && sel <= 7) || (sel == 8);
      if (sel == 8) im = 1'b1;
      step(r, c, s, t, im, is);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencing controller for the 4-digit seven-segment display.
- Holds a user-set MM:SS preset and counts it down to 00:00 on a 1 Hz tick strobe, then flashes 00:00 as an alarm.
- Drives the display block's digit_3..digit_0 and enable_3..enable_0 inputs.
- Sits between the debounced button/tick logic and the display block.

Parameters:
- DONE_TICKS, 10, number of tick pulses spent in DONE (flashing) before automatic return to IDLE; legal range 1..255.
- BLANK_LEADING, 1, when 1, digit_3 is disabled whenever its value is 0, except in DONE.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle strobe, nominally 1 Hz.
- btn_start  input  1  one-cycle pulse: start / pause / resume toggle.
- btn_clear  input  1  one-cycle pulse: abort and return to IDLE.
- btn_inc_min  input  1  one-cycle pulse: preset minutes +1.
- btn_inc_sec  input  1  one-cycle pulse: preset seconds +1.
- digit_3  output  4  BCD minutes tens.
- digit_2  output  4  BCD minutes ones.
- digit_1  output  4  BCD seconds tens.
- digit_0  output  4  BCD seconds ones.
- enable_3  output  1  digit enable, 1 = lit.
- enable_2  output  1  digit enable, 1 = lit.
- enable_1  output  1  digit enable, 1 = lit.
- enable_0  output  1  digit enable, 1 = lit.
- running  output  1  1 while in RUN.
- expired  output  1  1 while in DONE.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; preset=00:00; count=00:00; blink_phase=1; done_cnt=0.
  - Outputs: digits 0,0,0,0; enable_3=~BLANK_LEADING; enable_2..0=1; running=0; expired=0.
  - Reset overrides every other input, mid-run included.
- Timing: every output is derived from registers only. An event sampled at edge N is visible after edge N; there is no further latency.
- Input priority, same cycle: rst > btn_clear > btn_start > tick > btn_inc_*.
  - Exception: in RUN, a tick and a btn_start in the same cycle both act. The decrement is applied and the state goes to PAUSE.
- IDLE:
  - Display shows preset.
  - btn_inc_sec: seconds 00..59, wraps 59->00 with no carry into minutes.
  - btn_inc_min: minutes 00..99, wraps 99->00.
  - btn_inc_min and btn_inc_sec together: both applied.
  - btn_start with preset != 00:00: count<=preset, go to RUN.
  - btn_start with preset == 00:00: ignored.
  - tick: ignored.
- RUN:
  - Display shows count.
  - On tick, count decrements by 1 s in BCD:
    - seconds ones 0 borrows from seconds tens;
    - seconds 00 becomes 59 and borrows from minutes;
    - minutes ones 0 borrows from minutes tens.
  - If the post-decrement value is 00:00: go to DONE on the same edge; blink_phase<=1; done_cnt<=0.
  - btn_start: go to PAUSE.
- PAUSE:
  - count frozen; display shows count; ticks ignored.
  - btn_start: go to RUN.
- DONE:
  - Display shows 00:00; expired=1.
  - Each tick: blink_phase toggles and done_cnt increments.
  - All four enables = blink_phase; leading blanking is not applied.
  - When a tick makes done_cnt reach DONE_TICKS: go to IDLE, count<=preset, blink_phase<=1.
  - btn_start: ignored.
- btn_clear in any state other than IDLE: go to IDLE, count<=preset. Preset is retained.
- btn_clear in IDLE: no effect.
- btn_inc_* outside IDLE: ignored.
- Leading blanking (BLANK_LEADING=1): in IDLE, RUN and PAUSE, enable_3=0 iff digit_3==0. All other enables=1.
- Count never underflows: a decrement from 00:00 cannot occur, because 00:00 is never in RUN.

Decomposition:
- Package countdown_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE};
  - constants SEC_MAX_TENS=5, MIN_MAX=99, BCD_WIDTH=4.
- Sub-module mmss_counter:
  - 4-digit BCD register with load, decrement_en and is_zero (combinational flag for the post-decrement value).
  - countdown_ctrl instantiates one for count.
  - The preset increment logic stays local.

Test Plan:
- Reset, then btn_inc_sec x61 and btn_inc_min x3 -> preset 03:01; digits 0,3,0,1; enable_3=0; others 1.
- Preset 00:03, btn_start, 3 ticks:
  - after the start edge: running=1, display 00:03;
  - after each tick: 00:02, 00:01, 00:00;
  - expired=1 on the third tick's edge.
- Preset 10:00, start, 1 tick -> display 09:59 (digits 0,9,5,9).
- In RUN at 00:05: tick and btn_start in the same cycle -> 00:04, state PAUSE. Two more ticks -> still 00:04. btn_start -> running=1.
- DONE with DONE_TICKS=4:
  - enables all 1 at entry;
  - enables all 0, 1, 0 after ticks 1..3;
  - after tick 4: IDLE, display = preset, expired=0.
- Mid-run cases:
  - btn_clear at 01:30 of a 02:00 run -> IDLE, display 02:00.
  - rst mid-run -> display 00:00, preset cleared.
  - btn_start with preset 00:00 -> stays IDLE.
